// File: rtl/rs_age_multi_cdb.sv
// Age-ordered reservation station with NUM_CDB wakeup ports and free count.
// Optional RS_FLUSH_EN adds a synchronous flush input.
module rs_age_multi_cdb #(
   parameter int RS_DEPTH = 8,
   parameter int NUM_CDB = 2,
   parameter int NUM_FU = 5,
   parameter int TAG_W = 6,
   parameter int INST_W = 32,
   parameter int IDX_W = $clog2(RS_DEPTH),
   localparam int FU_W = $clog2(NUM_FU),
   localparam int CNT_W = $clog2(RS_DEPTH + 1)
) (
   input  logic                     clock,
   input  logic                     reset,
`ifdef RS_FLUSH_EN
   input  logic                     flush,
`endif
   input  logic                     alloc_valid,
   output logic                     alloc_ready,
   input  logic [FU_W-1:0]          alloc_fu,
   input  logic [INST_W-1:0]        alloc_inst,
   input  logic [TAG_W-1:0]         alloc_dest,
   input  logic [TAG_W-1:0]         alloc_src1,
   input  logic [TAG_W-1:0]         alloc_src2,
   input  logic                     alloc_src1_rdy,
   input  logic                     alloc_src2_rdy,
   input  logic [NUM_CDB-1:0]       cdb_valid,
   input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
   input  logic [NUM_FU-1:0]        fu_busy,
   input  logic                     issue_en,
   output logic                     issue_valid,
   output logic [FU_W-1:0]          issue_fu,
   output logic [INST_W-1:0]        issue_inst,
   output logic [TAG_W-1:0]         issue_dest,
   output logic [TAG_W-1:0]         issue_src1,
   output logic [TAG_W-1:0]         issue_src2,
   output logic [IDX_W-1:0]         issue_index,
   output logic [CNT_W-1:0]         free_count
);

   logic [RS_DEPTH-1:0] vld_q, s1r_q, s2r_q;
   logic [FU_W-1:0]     fu_q   [RS_DEPTH];
   logic [INST_W-1:0]   inst_q [RS_DEPTH];
   logic [TAG_W-1:0]    dest_q [RS_DEPTH];
   logic [TAG_W-1:0]    s1_q   [RS_DEPTH];
   logic [TAG_W-1:0]    s2_q   [RS_DEPTH];
   // older_q[i][j] set: entry i was allocated before entry j
   logic [RS_DEPTH-1:0] older_q [RS_DEPTH];
   logic [CNT_W-1:0]    free_q;

   logic [RS_DEPTH-1:0] fu_blk, elig, pick;
   logic [IDX_W-1:0]    alloc_idx;
   logic                do_alloc, do_issue;

   function automatic logic cdb_hit(
      input logic [TAG_W-1:0]         tag,
      input logic [NUM_CDB-1:0]       v,
      input logic [NUM_CDB*TAG_W-1:0] t
   );
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < NUM_CDB; k++)
         if (v[k] && t[k*TAG_W +: TAG_W] == tag && tag != '0)
            hit = 1'b1;
      return hit;
   endfunction

   always_comb begin
      fu_blk = '0;
      elig = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         for (int f = 0; f < NUM_FU; f++)
            if (fu_q[i] == FU_W'(f)) fu_blk[i] = fu_busy[f];
         elig[i] = vld_q[i] & s1r_q[i] & s2r_q[i] & ~fu_blk[i];
      end
   end

   // An eligible entry wins unless some older entry is also eligible
   always_comb begin
      pick = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         pick[i] = elig[i];
         for (int j = 0; j < RS_DEPTH; j++)
            if (j != i && elig[j] && older_q[j][i]) pick[i] = 1'b0;
      end
   end

   always_comb begin
      issue_valid = |elig;
      issue_index = '0;
      issue_fu = '0;
      issue_inst = '0;
      issue_dest = '0;
      issue_src1 = '0;
      issue_src2 = '0;
      for (int i = 0; i < RS_DEPTH; i++)
         if (pick[i]) begin
            issue_index = IDX_W'(i);
            issue_fu = fu_q[i];
            issue_inst = inst_q[i];
            issue_dest = dest_q[i];
            issue_src1 = s1_q[i];
            issue_src2 = s2_q[i];
         end
   end

   always_comb begin
      alloc_idx = '0;
      for (int i = RS_DEPTH - 1; i >= 0; i--)
         if (!vld_q[i]) alloc_idx = IDX_W'(i);
   end

   assign alloc_ready = ~&vld_q;
   assign do_alloc = alloc_valid & alloc_ready;
   assign do_issue = issue_valid & issue_en;
   assign free_count = free_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vld_q <= '0;
         s1r_q <= '0;
         s2r_q <= '0;
         free_q <= CNT_W'(RS_DEPTH);
         for (int i = 0; i < RS_DEPTH; i++) begin
            fu_q[i] <= '0;
            inst_q[i] <= '0;
            dest_q[i] <= '0;
            s1_q[i] <= '0;
            s2_q[i] <= '0;
            older_q[i] <= '0;
         end
      end
`ifdef RS_FLUSH_EN
      else if (flush) begin
         vld_q <= '0;
         free_q <= CNT_W'(RS_DEPTH);
      end
`endif
      else begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            if (cdb_hit(s1_q[i], cdb_valid, cdb_tag)) s1r_q[i] <= 1'b1;
            if (cdb_hit(s2_q[i], cdb_valid, cdb_tag)) s2r_q[i] <= 1'b1;
         end
         if (do_issue) vld_q[issue_index] <= 1'b0;
         if (do_alloc) begin
            vld_q[alloc_idx] <= 1'b1;
            fu_q[alloc_idx] <= alloc_fu;
            inst_q[alloc_idx] <= alloc_inst;
            dest_q[alloc_idx] <= alloc_dest;
            s1_q[alloc_idx] <= alloc_src1;
            s2_q[alloc_idx] <= alloc_src2;
            s1r_q[alloc_idx] <= alloc_src1_rdy | (alloc_src1 == '0)
                              | cdb_hit(alloc_src1, cdb_valid, cdb_tag);
            s2r_q[alloc_idx] <= alloc_src2_rdy | (alloc_src2 == '0)
                              | cdb_hit(alloc_src2, cdb_valid, cdb_tag);
            for (int j = 0; j < RS_DEPTH; j++)
               older_q[j][alloc_idx] <= vld_q[j];
            older_q[alloc_idx] <= '0;
         end
         if (do_alloc && !do_issue)
            free_q <= free_q - CNT_W'(1);
         else if (do_issue && !do_alloc)
            free_q <= free_q + CNT_W'(1);
      end
   end

endmodule
